// File: rtl/parity_check_stream_pkg.sv
// Shared types and constants for the parity_check_stream slice.
package parity_pkg;

    // Frame tracking: IDLE between frames, IN_FRAME after a non-last word.
    typedef enum logic {
        IDLE,
        IN_FRAME
    } pc_state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage : parity_pkg

// File: rtl/parity_check_stream_calc.sv
// Combinational XOR reduction of a word plus its parity bit.
module parity_calc #(
    parameter int unsigned W = 9
) (
    input  logic [W-1:0] bits_i,
    output logic         par_o
);

    // Odd number of ones in bits_i gives 1.
    always_comb begin
        par_o = ^bits_i;
    end

endmodule : parity_calc

// File: rtl/parity_check_stream.sv
// Registered valid/ready parity checker with per-word and per-frame error flags.
// Optional saturating error counter enabled by `PARITY_ERR_CNT_EN.
module parity_check_stream
    import parity_pkg::*;
#(
    parameter int unsigned DATA_W  = 8,
    parameter logic        ODD_PAR = PAR_EVEN,
    parameter int unsigned CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              odd_mode,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_parity,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_err,
    output logic              out_last,
    output logic              out_frm_err
`ifdef PARITY_ERR_CNT_EN
    ,
    output logic [CNT_W-1:0]  err_cnt,
    input  logic              err_clr
`endif
);

    pc_state_t         state_q, state_d;
    logic              mode_q, mode_d;
    logic              acc_q, acc_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_err_q, out_err_d;
    logic              out_last_q, out_last_d;
    logic              out_frm_err_q, out_frm_err_d;

    logic              in_xfer;
    logic              mode_eff;
    logic              raw_par;
    logic              word_err;

    parity_calc #(
        .W (DATA_W + 1)
    ) u_calc (
        .bits_i ({in_data, in_parity}),
        .par_o  (raw_par)
    );

    // Handshake and word error; a frame's first word already uses the fresh mode.
    always_comb begin
        in_ready = !out_valid_q || out_ready;
        in_xfer  = in_valid && in_ready;
        mode_eff = (state_q == IDLE) ? odd_mode : mode_q;
        word_err = raw_par ^ mode_eff;
    end

    // Next-state for FSM, frame accumulator and output register.
    always_comb begin
        state_d       = state_q;
        mode_d        = mode_q;
        acc_d         = acc_q;
        out_valid_d   = out_valid_q;
        out_data_d    = out_data_q;
        out_err_d     = out_err_q;
        out_last_d    = out_last_q;
        out_frm_err_d = out_frm_err_q;

        if (in_xfer) begin
            out_valid_d   = 1'b1;
            out_data_d    = in_data;
            out_err_d     = word_err;
            out_last_d    = in_last;
            out_frm_err_d = in_last && (acc_q || word_err);
            acc_d         = in_last ? 1'b0 : (acc_q || word_err);

            unique case (state_q)
                IDLE: begin
                    mode_d = odd_mode;
                    if (!in_last) begin
                        state_d = IN_FRAME;
                    end
                end
                IN_FRAME: begin
                    if (in_last) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (out_ready) begin
            // Payload is left as-is; only the valid flag drops once consumed.
            out_valid_d = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            mode_q        <= ODD_PAR;
            acc_q         <= 1'b0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_err_q     <= 1'b0;
            out_last_q    <= 1'b0;
            out_frm_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            mode_q        <= mode_d;
            acc_q         <= acc_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            out_err_q     <= out_err_d;
            out_last_q    <= out_last_d;
            out_frm_err_q <= out_frm_err_d;
        end
    end

    // Drive ports from the output register.
    always_comb begin
        out_valid   = out_valid_q;
        out_data    = out_data_q;
        out_err     = out_err_q;
        out_last    = out_last_q;
        out_frm_err = out_frm_err_q;
    end

`ifdef PARITY_ERR_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Saturating bad-word count; clear wins over a same-cycle increment.
    always_comb begin
        cnt_d = cnt_q;
        if (err_clr) begin
            cnt_d = '0;
        end else if (in_xfer && word_err && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Counter output.
    always_comb begin
        err_cnt = cnt_q;
    end
`else
    // CNT_W has no role when the counter is absent.
    localparam int unsigned unused_cnt_w = CNT_W;
`endif

endmodule : parity_check_stream

// File: tb/tb_parity_check_stream.sv
// Scoreboard bench for parity_check_stream; counter checks when `PARITY_ERR_CNT_EN is set.
module tb_parity_check_stream;
    import parity_pkg::*;

    localparam int unsigned DW     = 8;
    localparam int unsigned CW     = 2;
    localparam int unsigned CNTMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          odd_mode;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          in_parity;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_err;
    logic          out_last;
    logic          out_frm_err;
    logic          err_clr;
`ifdef PARITY_ERR_CNT_EN
    logic [CW-1:0] err_cnt;
`endif

    always #5 clk = ~clk;

    parity_check_stream #(
        .DATA_W  (DW),
        .ODD_PAR (PAR_EVEN),
        .CNT_W   (CW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .odd_mode    (odd_mode),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_parity   (in_parity),
        .in_last     (in_last),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_err     (out_err),
        .out_last    (out_last),
        .out_frm_err (out_frm_err)
`ifdef PARITY_ERR_CNT_EN
        ,
        .err_cnt     (err_cnt),
        .err_clr     (err_clr)
`endif
    );

    typedef struct {
        logic [DW-1:0] data;
        logic          err;
        logic          last;
        logic          frm;
    } exp_t;

    exp_t        sbq[$];
    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    // Reference model state, kept in frame terms.
    bit          m_in_frame = 1'b0;
    bit          m_mode     = 1'b0;
    bit          m_any_bad  = 1'b0;
    int unsigned m_cnt      = 0;
    bit          acc_now    = 1'b0;
    bit          prev_acc   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Even mode: word bad when the total ones count (data + parity) is odd; odd mode: when even.
    function automatic bit ref_bad(input logic [DW-1:0] d, input logic p, input bit odd);
        int unsigned ones;
        ones = $countones(d) + (p ? 1 : 0);
        if (!odd) return (ones % 2) == 1;
        return (ones % 2) == 0;
    endfunction

    // Monitor and model: outputs compared first, then this cycle's accepted input enters the model.
    always @(negedge clk) begin
        exp_t e;
        bit   bad;
        acc_now = 1'b0;
        bad     = 1'b0;
        if (!rst_n) begin
            sbq.delete();
            m_in_frame = 1'b0;
            m_any_bad  = 1'b0;
            m_cnt      = 0;
            prev_acc   = 1'b0;
        end else begin
            if (prev_acc) check("latency_out_valid", out_valid, 1);
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL extra_output: data 0x%0h presented, expected nothing", out_data);
                end else begin
                    e = sbq.pop_front();
                    check("out_data", out_data, e.data);
                    check("out_err", out_err, e.err);
                    check("out_last", out_last, e.last);
                    check("out_frm_err", out_frm_err, e.frm);
                end
            end
`ifdef PARITY_ERR_CNT_EN
            check("err_cnt", err_cnt, m_cnt);
`endif
            if (in_valid && in_ready) begin
                if (!m_in_frame) m_mode = odd_mode;
                bad       = ref_bad(in_data, in_parity, m_mode);
                e.data    = in_data;
                e.err     = bad;
                e.last    = in_last;
                e.frm     = in_last && (m_any_bad || bad);
                sbq.push_back(e);
                if (in_last) begin
                    m_in_frame = 1'b0;
                    m_any_bad  = 1'b0;
                end else begin
                    m_in_frame = 1'b1;
                    m_any_bad  = m_any_bad || bad;
                end
                acc_now = 1'b1;
            end
`ifdef PARITY_ERR_CNT_EN
            if (err_clr) m_cnt = 0;
            else if (acc_now && bad && m_cnt < CNTMAX) m_cnt++;
`endif
            prev_acc = acc_now;
        end
    end

    // Wait (bounded) for the currently presented word to be taken.
    task automatic wait_acc(input string name);
        int unsigned i;
        i = 0;
        do begin
            @(posedge clk);
            i++;
        end while (!acc_now && i < 50);
        if (!acc_now) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s_timeout: word not accepted in 50 cycles, expected acceptance", name);
        end
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send(input logic [DW-1:0] d, input logic p, input logic l, input logic om);
        in_valid  = 1'b1;
        in_data   = d;
        in_parity = p;
        in_last   = l;
        odd_mode  = om;
        wait_acc("send");
    endtask

    task automatic drain();
        out_ready = 1'b1;
        in_valid  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b1;
        odd_mode  = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_parity = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        err_clr   = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_frm_err", out_frm_err, 0);
        check("rst_in_ready", in_ready, 1);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Even mode: clean then bad word.
        send(8'h05, 1'b0, 1'b0, 1'b0);
        send(8'h0D, 1'b0, 1'b1, 1'b0);

        // Odd mode latched at frame start; mid-frame toggle ignored.
        send(8'h05, 1'b0, 1'b0, 1'b1);
        send(8'h0D, 1'b0, 1'b1, 1'b0);

        // Three-word frame with bad middle word, then a clean frame.
        send(8'h03, 1'b0, 1'b0, 1'b0);
        send(8'h01, 1'b0, 1'b0, 1'b0);
        send(8'hFF, 1'b0, 1'b1, 1'b0);
        send(8'h00, 1'b0, 1'b0, 1'b0);
        send(8'h81, 1'b0, 1'b1, 1'b0);

        // Back-pressure: payload holds and the next word waits.
        drain();
        out_ready = 1'b0;
        send(8'hA5, 1'b0, 1'b0, 1'b0);
        in_valid  = 1'b1;
        in_data   = 8'h3C;
        in_parity = 1'b0;
        in_last   = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("stall_in_ready", in_ready, 0);
            check("stall_out_valid", out_valid, 1);
            check("stall_out_data", out_data, 8'hA5);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        wait_acc("stall_release");

`ifdef PARITY_ERR_CNT_EN
        // Saturation and clear-over-increment.
        drain();
        err_clr = 1'b1;
        @(posedge clk);
        #1 err_clr = 1'b0;
        repeat (5) send(8'h01, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        check("cnt_saturated", err_cnt, CNTMAX);
        err_clr = 1'b1;
        send(8'h01, 1'b0, 1'b1, 1'b0);
        err_clr = 1'b0;
        check("cnt_clr_priority", err_cnt, 0);
`endif

        // Reset during an odd-mode frame while stalled.
        drain();
        out_ready = 1'b0;
        send(8'h11, 1'b0, 1'b0, 1'b1);
        in_valid  = 1'b1;
        in_data   = 8'h22;
        in_parity = 1'b0;
        in_last   = 1'b1;
        #3 rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_out_data", out_data, 0);
        check("mid_rst_out_err", out_err, 0);
        check("mid_rst_out_last", out_last, 0);
        check("mid_rst_out_frm_err", out_frm_err, 0);
        check("mid_rst_in_ready", in_ready, 1);
`ifdef PARITY_ERR_CNT_EN
        check("mid_rst_err_cnt", err_cnt, 0);
`endif
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b1;
        send(8'h03, 1'b0, 1'b1, 1'b0);
        send(8'h07, 1'b1, 1'b0, 1'b0);
        send(8'h07, 1'b0, 1'b1, 1'b0);

        // Randomised traffic; a word not yet taken is held.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            if (!in_valid || acc_now) begin
                in_valid  = ($urandom_range(0, 3) != 0);
                in_data   = DW'($urandom);
                in_parity = 1'($urandom);
                in_last   = ($urandom_range(0, 3) == 0);
            end
            odd_mode  = 1'($urandom);
            out_ready = ($urandom_range(0, 9) < 7);
            err_clr   = ($urandom_range(0, 31) == 0);
        end
        err_clr = 1'b0;
        drain();
        check("scoreboard_empty", sbq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_parity_check_stream
